// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch front end. Drives a word-aligned fetch address to an
// instruction memory with one cycle of read latency. It tags each returned
// word with the address that produced it and hands {pc, instr} pairs to
// decode over a valid/ready handshake. A 2-entry buffer holds responses that
// are still in flight when decode stalls, so no word is lost or duplicated.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-low reset
//   imem_addr      : registered fetch byte address to instruction memory
//   imem_data      : memory word for the address presented last cycle
//   redirect_valid : one-cycle pulse, flush and restart fetch at redirect_pc
//   redirect_pc    : redirect target, low two bits ignored
//   out_valid      : buffer head holds a valid instruction
//   out_ready      : decode accepts the head this cycle
//   out_instr      : head instruction word (0 when not valid)
//   out_pc         : byte address of out_instr (0 when not valid)

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic [31:0] fetchPc_q, fetchPc_d;
    logic        reqValid_q, reqValid_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] entryPc_q    [2];
    logic [31:0] entryInstr_q [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic        tailIdx;
    logic [2:0]  pending;

    // Handshake and buffer bookkeeping. The occupancy test counts the word
    // already in flight so that a request is only issued when its response
    // is guaranteed a free slot on arrival. A response landing in the same
    // cycle as a redirect belongs to the old path and is discarded.
    always_comb begin
        pop     = out_valid & out_ready;
        pending = {1'b0, count_q} + {2'b00, reqValid_q} - {2'b00, pop};
        issue   = (pending < 3'd2);
        push    = reqValid_q & ~redirect_valid;
        tailIdx = head_q ^ count_q[0];
    end

    // Next-state selection. Redirect overrides the normal fetch/issue path.
    // On a stall the fetch address is simply held, so memory re-reads the
    // same word and that response is never pushed.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        reqValid_d = 1'b0;
        reqPc_d    = reqPc_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        head_d     = head_q ^ pop;
        if (redirect_valid) begin
            fetchPc_d  = redirect_pc & 32'hFFFF_FFFC;
            reqValid_d = 1'b0;
            count_d    = 2'd0;
            head_d     = 1'b0;
        end else if (issue) begin
            fetchPc_d  = fetchPc_q + 32'd4;
            reqValid_d = 1'b1;
            reqPc_d    = fetchPc_q;
        end
    end

    // Control state registers. Reset wins over a simultaneous redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetchPc_q  <= RESET_PC;
            reqValid_q <= 1'b0;
            reqPc_q    <= RESET_PC;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            reqValid_q <= reqValid_d;
            reqPc_q    <= reqPc_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // Buffer storage. Entries carry no reset because the occupancy count
    // decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            entryPc_q[tailIdx]    <= reqPc_q;
            entryInstr_q[tailIdx] <= imem_data;
        end
    end

    // Outputs come from registers only, so out_valid has no combinational
    // path from out_ready or redirect_valid.
    always_comb begin
        imem_addr = fetchPc_q;
        out_valid = (count_q != 2'd0);
        out_instr = out_valid ? entryInstr_q[head_q] : 32'd0;
        out_pc    = out_valid ? entryPc_q[head_q]    : 32'd0;
    end

    // The issue rule must make a push into a full buffer impossible.
    noOverflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// -------------
// Directed bench for fetch_unit. The memory model returns 0x1000_0000 plus
// the word index one cycle after the address is presented. Inputs are driven
// and outputs sampled on the falling edge, away from the active edge.

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks   = 0;
    int failures = 0;
    logic [31:0] expPc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory: word i holds 0x1000_0000 + i.
    always @(posedge clk) begin
        imem_data <= 32'h1000_0000 + (imem_addr >> 2);
    end

    // Drives every DUT input in one place.
    task automatic applyStimulus(input logic rstVal, input logic readyVal,
                                 input logic redirVal, input logic [31:0] redirPc);
        rst            = rstVal;
        out_ready      = readyVal;
        redirect_valid = redirVal;
        redirect_pc    = redirPc;
    endtask

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advances to the next sampling point.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        tick(2);

        // Held in reset.
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_addr",  imem_addr, 32'h0000_0000);
        checkOutput("rst_pc",    out_pc,    32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);

        // Release: cycle 0 here, first output in cycle 2.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("c0_addr",  imem_addr, 32'h0000_0000);
        checkOutput("c0_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        checkOutput("c1_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("c1_addr",  imem_addr, 32'h0000_0004);
        tick(1);

        // Free run, one instruction per cycle.
        expPc = 32'd0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("run_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("run_pc",    out_pc,    expPc);
            checkOutput("run_instr", out_instr, 32'h1000_0000 + (expPc >> 2));
            tick(1);
            expPc = expPc + 32'd4;
        end
        checkOutput("run_addr", imem_addr, expPc + 32'd8);

        // Stall for 5 cycles: head held, fetch address frozen.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_pc",    out_pc,    expPc);
            checkOutput("stall_addr",  imem_addr, expPc + 32'd8);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            expPc = expPc + 32'd4;
            checkOutput("resume_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("resume_pc",    out_pc,    expPc);
            checkOutput("resume_instr", out_instr, 32'h1000_0000 + (expPc >> 2));
        end

        // Redirect to 0x40 while streaming.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("redir_t1_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("redir_t1_addr",  imem_addr, 32'h0000_0040);
        tick(1);
        checkOutput("redir_t2_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        checkOutput("redir_t3_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("redir_t3_pc",    out_pc,    32'h0000_0040);
        checkOutput("redir_t3_instr", out_instr, 32'h1000_0010);
        tick(1);
        checkOutput("redir_t4_pc",    out_pc,    32'h0000_0044);
        checkOutput("redir_t4_instr", out_instr, 32'h1000_0011);

        // Fill the buffer, then redirect to an unaligned target.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick(3);
        checkOutput("full_pc",   out_pc,    32'h0000_0044);
        checkOutput("full_addr", imem_addr, 32'h0000_004C);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0083);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_addr",  imem_addr, 32'h0000_0080);
        checkOutput("flush_pc",    out_pc,    32'd0);
        checkOutput("flush_instr", out_instr, 32'd0);
        tick(1);
        checkOutput("flush_t2_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        checkOutput("flush_t3_pc",    out_pc,    32'h0000_0080);
        checkOutput("flush_t3_instr", out_instr, 32'h1000_0020);
        tick(1);
        checkOutput("flush_hold_pc",  out_pc,    32'h0000_0080);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick(1);
        checkOutput("flush_next_pc",    out_pc,    32'h0000_0084);
        checkOutput("flush_next_instr", out_instr, 32'h1000_0021);
        tick(1);
        checkOutput("flush_next2_pc",   out_pc,    32'h0000_0088);

        // Address wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("wrap_t1_addr",  imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_t1_valid", {31'd0, out_valid}, 32'd0);
        tick(1);
        checkOutput("wrap_t2_addr",  imem_addr, 32'h0000_0000);
        tick(1);
        checkOutput("wrap_top_pc",    out_pc,    32'hFFFF_FFFC);
        checkOutput("wrap_top_instr", out_instr, 32'h4FFF_FFFF);
        tick(1);
        checkOutput("wrap_zero_pc",    out_pc,    32'h0000_0000);
        checkOutput("wrap_zero_instr", out_instr, 32'h1000_0000);
        tick(1);
        checkOutput("wrap_four_pc",    out_pc,    32'h0000_0004);

        // Reset while full and stalled, with a competing redirect.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick(3);
        checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_addr",  imem_addr, 32'h0000_0000);
        checkOutput("mid_rst_pc",    out_pc,    32'd0);
        checkOutput("mid_rst_instr", out_instr, 32'd0);
        tick(1);
        checkOutput("mid_rst_c1_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_c1_addr",  imem_addr, 32'h0000_0004);
        tick(1);
        checkOutput("mid_rst_c2_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("mid_rst_c2_pc",    out_pc,    32'h0000_0000);
        checkOutput("mid_rst_c2_instr", out_instr, 32'h1000_0000);
        tick(1);
        checkOutput("mid_rst_c3_pc",    out_pc,    32'h0000_0004);
        checkOutput("mid_rst_c3_instr", out_instr, 32'h1000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: the initiator that drives the instruction memory's word-address port and consumes its registered read data. It generates the sequential PC, accepts branch/jump redirects, compensates for the memory's one-cycle read latency, and presents instructions tagged with their PC to decode over a valid/ready handshake. A 2-entry buffer absorbs in-flight responses when decode stalls, so no fetched word is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (rst=0 resets)
- imem_addr  output  32  byte address to instruction memory; registered (fetch PC)
- imem_data  input  32  memory read data; holds word at the imem_addr presented in the previous cycle
- redirect_valid  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
- out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
- out_ready  input  1  decode accepts; transfer when out_valid & out_ready
- out_instr  output  32  instruction word (buffer head)
- out_pc  output  32  byte address of out_instr

## Operation
- State: fetch PC register (drives imem_addr), req_q/req_pc_q (a request was issued last cycle, its PC), 2-entry FIFO of {pc, instr}, occupancy count 0..2.
- pop = out_valid & out_ready. Issue condition: count + req_q - pop < 2.
- Issue: req_q <= 1, req_pc_q <= pc, pc <= pc + 4 (modulo 2^32; 0xFFFF_FFFC wraps to 0). No issue: req_q <= 0, pc held (memory re-reads same word; response ignored).
- Push: when req_q = 1, write {req_pc_q, imem_data} at FIFO tail in the same cycle.
- Push and pop in the same cycle are both performed; count changes by push - pop. FIFO can never overflow; overflow is an assertion failure.
- out_valid = (count != 0). out_instr/out_pc = head entry when valid, 0 when not.
- Redirect (priority over all else): count <= 0, req_q <= 0, the response arriving this cycle is not pushed, pc <= {redirect_pc[31:2], 2'b00}. A handshake completing in the redirect cycle counts as a completed transfer.
- Reset (rst=0, any cycle including mid-stall or mid-redirect): pc <= RESET_PC, req_q <= 0, count <= 0. Outputs during/after reset edge: imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0. rst dominates redirect_valid.
- No state machine beyond occupancy/in-flight tracking; out_valid never combinationally depends on out_ready or redirect_valid.

## Timing
- Memory latency: 1 cycle (data for address at cycle t valid at t+1).
- Fetch-to-output: address issued at cycle t -> pushed at t+1 -> out_valid at t+2.
- After reset release at edge E: imem_addr = RESET_PC in cycle 0, out_valid = 1 in cycle 2 with out_pc = RESET_PC.
- Throughput: with out_ready held 1, one instruction per cycle, out_pc incrementing by 4 each cycle, no bubbles.
- Stall: out_ready low -> head stable; issue stops once count + req_q reaches 2; at most 2 words buffered; fetch resumes the cycle of the first pop.
- Redirect at cycle t: out_valid = 0 at t+1, imem_addr = target at t+1, out_valid = 1 at t+3 with out_pc = target.

## Test plan
- Reset/free-run: memory model word[i] = 0x1000_0000 + i, RESET_PC = 0, out_ready = 1 -> out_valid first at cycle 2, out_pc 0,4,8,... with out_instr 0x1000_0000, 0x1000_0001,... one per cycle.
- Stall: drop out_ready for 5 cycles mid-stream -> head held, count saturates at 2, imem_addr stops advancing; on release, sequence continues with no gap, duplicate or loss.
- Redirect: pulse redirect_valid with redirect_pc = 0x40 while streaming -> next out_valid at t+3 with out_pc = 0x40, no instruction from the old path appears after t.
- Redirect with full buffer and out_ready = 0, redirect_pc = 0x83 -> buffer flushed, fetch restarts at 0x80, first out_pc = 0x80.
- Wrap: redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-operation: assert rst = 0 for 1 cycle while buffer full and out_ready = 0 -> out_valid = 0, imem_addr = RESET_PC next cycle; stream restarts from RESET_PC with 2-cycle latency.
